// File: rtl/hdlc_rx.sv
// hdlc_rx: serial HDLC frame receiver. Hunts 0x7E flags, deletes stuffed zeros,
// assembles bytes LSB-first, checks the CRC-16/CCITT FCS and reports frame status.
module hdlc_rx #(
   parameter int MAX_BYTES = 1024,
   parameter int CNT_W     = 11
) (
   input  logic       netclk,
   input  logic       reset,
   input  logic       rxdata,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       sop,
   output logic       frame_end,
   output logic       frame_good,
   output logic       err_crc,
   output logic       err_align,
   output logic       err_short,
   output logic       err_abort,
   output logic       err_long,
   output logic       in_frame
);
   typedef enum logic {HUNT, FRAME} state_t;

   localparam logic [15:0]      CRC_POLY = 16'h1021;
   localparam logic [15:0]      CRC_GOOD = 16'h1D0F;
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BYTES + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_SAT) ? CNT_SAT : v + CNT_W'(1);
   endfunction

   state_t           state_q, state_d;
   logic [2:0]       ones_q, ones_d, ones_inc;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [15:0]      lfsr_q, lfsr_d, crc_snap_q, crc_snap_d;
   logic [7:0]       shreg_q, shreg_d, pipe0_q, pipe0_d, pipe1_q, pipe1_d;
   logic             long_q, long_d;
   logic [7:0]       dout_q, dout_d;
   logic             dvld_q, dvld_d, sop_q, sop_d, fend_q, fend_d, fgood_q, fgood_d;
   logic             ecrc_q, ecrc_d, ealign_q, ealign_d, eshort_q, eshort_d;
   logic             eabort_q, eabort_d, elong_q, elong_d, in_frame_q, in_frame_d;
   logic             is_flag, is_abort, data_bit, aligned, short_v, crc_bad, fb;

   always_comb begin
      ones_inc = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
      ones_d   = rxdata ? ones_inc : 3'd0;
      is_flag  = !rxdata && (ones_q == 3'd6);
      is_abort = rxdata && (ones_q == 3'd6);
      // ones 1..6 are provisional data; a zero after five ones is a stuffed bit
      data_bit = rxdata ? (ones_inc <= 3'd6) : (ones_q < 3'd5);

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      lfsr_d     = lfsr_q;
      crc_snap_d = crc_snap_q;
      shreg_d    = shreg_q;
      pipe0_d    = pipe0_q;
      pipe1_d    = pipe1_q;
      long_d     = long_q;
      dout_d     = dout_q;
      dvld_d     = 1'b0;
      sop_d      = 1'b0;
      fend_d     = 1'b0;
      fgood_d    = 1'b0;
      ecrc_d     = 1'b0;
      ealign_d   = 1'b0;
      eshort_d   = 1'b0;
      eabort_d   = 1'b0;
      elong_d    = 1'b0;
      aligned    = (bit_cnt_q == 3'd7);
      short_v    = (byte_cnt_q < CNT_W'(3));
      crc_bad    = aligned && !short_v && (crc_snap_q != CRC_GOOD);
      fb         = rxdata ^ lfsr_q[15];

      case (state_q)
         HUNT: begin
            if (is_flag) begin
               state_d    = FRAME;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = '0;
               long_d     = 1'b0;
               lfsr_d     = 16'hFFFF;
            end
         end
         FRAME: begin
            if (is_abort) begin
               if (byte_cnt_q != '0) begin
                  fend_d   = 1'b1;
                  eabort_d = 1'b1;
               end
               state_d    = HUNT;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = '0;
               long_d     = 1'b0;
            end else if (is_flag) begin
               // an aligned flag with no bytes before it is inter-frame fill
               if (!(aligned && byte_cnt_q == '0)) begin
                  fend_d   = 1'b1;
                  ealign_d = !aligned;
                  eshort_d = short_v;
                  ecrc_d   = crc_bad;
                  elong_d  = long_q;
                  fgood_d  = aligned && !short_v && !crc_bad && !long_q;
               end
               bit_cnt_d  = 3'd0;
               byte_cnt_d = '0;
               long_d     = 1'b0;
               lfsr_d     = 16'hFFFF;
            end else if (data_bit) begin
               lfsr_d    = {lfsr_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
               shreg_d   = {rxdata, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  crc_snap_d = lfsr_d;
                  pipe0_d    = shreg_d;
                  pipe1_d    = pipe0_q;
                  byte_cnt_d = sat_inc(byte_cnt_q);
                  if (byte_cnt_d > CNT_LIM) long_d = 1'b1;
                  // the two newest bytes are held back so the FCS is never emitted
                  if (byte_cnt_q >= CNT_W'(2) && byte_cnt_d <= CNT_LIM) begin
                     dvld_d = 1'b1;
                     dout_d = pipe1_q;
                     sop_d  = (byte_cnt_q == CNT_W'(2));
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
      in_frame_d = (state_d == FRAME);
   end

   always_ff @(posedge netclk or posedge reset) begin
      if (reset) begin
         state_q    <= HUNT;
         ones_q     <= 3'd0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= '0;
         lfsr_q     <= 16'hFFFF;
         crc_snap_q <= 16'h0000;
         shreg_q    <= 8'h00;
         pipe0_q    <= 8'h00;
         pipe1_q    <= 8'h00;
         long_q     <= 1'b0;
         dout_q     <= 8'h00;
         dvld_q     <= 1'b0;
         sop_q      <= 1'b0;
         fend_q     <= 1'b0;
         fgood_q    <= 1'b0;
         ecrc_q     <= 1'b0;
         ealign_q   <= 1'b0;
         eshort_q   <= 1'b0;
         eabort_q   <= 1'b0;
         elong_q    <= 1'b0;
         in_frame_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ones_q     <= ones_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         lfsr_q     <= lfsr_d;
         crc_snap_q <= crc_snap_d;
         shreg_q    <= shreg_d;
         pipe0_q    <= pipe0_d;
         pipe1_q    <= pipe1_d;
         long_q     <= long_d;
         dout_q     <= dout_d;
         dvld_q     <= dvld_d;
         sop_q      <= sop_d;
         fend_q     <= fend_d;
         fgood_q    <= fgood_d;
         ecrc_q     <= ecrc_d;
         ealign_q   <= ealign_d;
         eshort_q   <= eshort_d;
         eabort_q   <= eabort_d;
         elong_q    <= elong_d;
         in_frame_q <= in_frame_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = dvld_q;
   assign sop        = sop_q;
   assign frame_end  = fend_q;
   assign frame_good = fgood_q;
   assign err_crc    = ecrc_q;
   assign err_align  = ealign_q;
   assign err_short  = eshort_q;
   assign err_abort  = eabort_q;
   assign err_long   = elong_q;
   assign in_frame   = in_frame_q;
endmodule

// File: tb/tb_hdlc_rx.sv
// Scoreboard bench for hdlc_rx: a stuffing line encoder issues frames and queues
// the expected bytes/status; an independent monitor checks every DUT strobe.
module tb_hdlc_rx;
   logic       netclk = 1'b0;
   logic       reset;
   logic       rxdata;
   logic [7:0] data_out;
   logic       data_valid, sop, frame_end, frame_good;
   logic       err_crc, err_align, err_short, err_abort, err_long, in_frame;

   hdlc_rx dut (
      .netclk(netclk), .reset(reset), .rxdata(rxdata),
      .data_out(data_out), .data_valid(data_valid), .sop(sop),
      .frame_end(frame_end), .frame_good(frame_good), .err_crc(err_crc),
      .err_align(err_align), .err_short(err_short), .err_abort(err_abort),
      .err_long(err_long), .in_frame(in_frame)
   );

   always #5 netclk = ~netclk;

   // status packing: {good, crc, align, short, abort, long}
   localparam logic [5:0] ST_GOOD  = 6'b100000;
   localparam logic [5:0] ST_CRC   = 6'b010000;
   localparam logic [5:0] ST_ALSH  = 6'b001100;
   localparam logic [5:0] ST_SHORT = 6'b000100;
   localparam logic [5:0] ST_ABORT = 6'b000010;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [8:0]  exp_bytes [$];
   logic [5:0]  exp_frames [$];
   int          tx_ones = 0;
   logic [15:0] tb_crc;
   logic [7:0]  pay [16];
   int          pay_n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes
   initial begin
      forever begin
         @(negedge netclk);
         if (data_valid && frame_end)
            check("dv_fe_exclusive", 32'(data_valid && frame_end), 32'd0);
         if (data_valid) begin
            if (exp_bytes.size() == 0) begin
               tests_run++; tests_failed++;
               $display("FAIL unexpected_byte: got sop=%0d data=0x%02h, expected none", sop, data_out);
            end else begin
               check("byte_sop_data", 32'({sop, data_out}), 32'(exp_bytes.pop_front()));
            end
         end
         if (frame_end) begin
            if (exp_frames.size() == 0) begin
               tests_run++; tests_failed++;
               $display("FAIL unexpected_frame_end: got status=%b, expected none",
                        {frame_good, err_crc, err_align, err_short, err_abort, err_long});
            end else begin
               check("frame_status",
                     32'({frame_good, err_crc, err_align, err_short, err_abort, err_long}),
                     32'(exp_frames.pop_front()));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic void crc_bit(input logic b);
      logic f;
      f = b ^ tb_crc[15];
      tb_crc = {tb_crc[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
   endfunction

   task automatic drive_raw(input logic b);
      @(negedge netclk);
      rxdata = b;
   endtask

   task automatic send_bit(input logic b);
      drive_raw(b);
      if (b) begin
         tx_ones++;
         if (tx_ones == 5) begin
            drive_raw(1'b0);
            tx_ones = 0;
         end
      end else begin
         tx_ones = 0;
      end
   endtask

   task automatic send_flag();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) drive_raw(f[i]);
      tx_ones = 0;
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) drive_raw(1'b1);
      tx_ones = 0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         crc_bit(v[i]);
         send_bit(v[i]);
      end
   endtask

   // Frame from pay[0..pay_n-1] with inverted FCS sent MSB-first; flip corrupts it
   task automatic send_frame(input logic [15:0] flip);
      logic [15:0] fcs;
      send_flag();
      tb_crc = 16'hFFFF;
      for (int i = 0; i < pay_n; i++) begin
         exp_bytes.push_back({(i == 0), pay[i]});
         send_byte(pay[i]);
      end
      fcs = ~tb_crc ^ flip;
      for (int i = 15; i >= 0; i--) send_bit(fcs[i]);
      exp_frames.push_back((flip == 16'h0) ? ST_GOOD : ST_CRC);
      send_flag();
      send_ones(10);
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({data_out, data_valid, sop, frame_end, frame_good, err_crc,
                       err_align, err_short, err_abort, err_long, in_frame}), 32'd0);
   endtask

   initial begin
      reset  = 1'b1;
      rxdata = 1'b1;
      repeat (3) @(negedge netclk);
      #1;
      check_all_zero("reset_outputs");
      reset = 1'b0;
      send_ones(16);
      check("idle_in_frame", 32'(in_frame), 32'd0);

      // basic good frame
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_n = 3;
      send_frame(16'h0000);

      // payload containing stuffed zeros on the line
      pay[0] = 8'hFF; pay[1] = 8'h3E; pay_n = 2;
      send_frame(16'h0000);

      // FCS corrupted in one bit
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_n = 3;
      send_frame(16'h0100);

      // misaligned closing flag: the flag's data bits complete a junk byte -> 2 bytes
      send_flag();
      send_byte(8'h55);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      exp_frames.push_back(ST_ALSH);
      send_flag();
      send_ones(10);

      // single byte between flags
      send_flag();
      send_byte(8'hAA);
      exp_frames.push_back(ST_SHORT);
      send_flag();
      send_ones(10);

      // abort after two bytes, then idle with no further strobes
      send_flag();
      send_byte(8'h12);
      send_byte(8'h34);
      #1;
      check("in_frame_before_abort", 32'(in_frame), 32'd1);
      exp_frames.push_back(ST_ABORT);
      send_ones(8);
      @(negedge netclk); #1;
      check("in_frame_after_abort", 32'(in_frame), 32'd0);
      send_ones(24);

      // flag fill then a good frame
      for (int i = 0; i < 5; i++) send_flag();
      pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'hC3; pay[3] = 8'h7E; pay_n = 4;
      send_frame(16'h0000);

      // asynchronous reset in the middle of a frame
      send_flag();
      send_byte(8'h11);
      send_byte(8'h22);
      send_bit(1'b1);
      send_bit(1'b0);
      #1;
      check("in_frame_mid_frame", 32'(in_frame), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset_outputs");
      repeat (3) @(negedge netclk);
      reset   = 1'b0;
      tx_ones = 0;
      send_ones(16);

      // recovery after reset
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_n = 3;
      send_frame(16'h0000);

      for (int k = 0; k < 100 && (exp_bytes.size() != 0 || exp_frames.size() != 0); k++)
         @(negedge netclk);
      check("scoreboard_drained", 32'(exp_bytes.size() + exp_frames.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
